// File: rtl/mips_fe_pkg.sv
// Shared front-end types for the MIPS fetch path: widths, reset PC and the queued fetch entry.
package mips_fe_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo_1w2r.sv
// Circular buffer of fetch entries: one write and zero to two reads per cycle, with flush.
module fetch_fifo_1w2r
  import mips_fe_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  wr_data,
  input  logic [1:0]    take,
  output logic          space,
  output fetch_entry_t  rd0,
  output fetch_entry_t  rd1,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [1:0]    take_req;
  logic [1:0]    take_eff;
  logic [CW-1:0] count_next;

  // Decode may ask for more than is queued; clamp to what is actually present.
  always_comb begin
    take_req = (take == 2'd0) ? 2'd0 : ((take == 2'd1) ? 2'd1 : 2'd2);
    take_eff = take_req;
    if (count < CW'(take_req)) take_eff = count[1:0];
  end

  assign space      = (count - CW'(take_eff)) < CW'(DEPTH);
  assign count_next = count + CW'(push) - CW'(take_eff);

  assign rd0 = mem[head];
  assign rd1 = mem[head + PW'(1)];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(take_eff);
      count <= count_next;
      if (push) tail <= tail + PW'(1);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wr_data;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch initiator: owns the fetch PC, reads one word per cycle and queues it for decode.
module fetch_queue_unit
  import mips_fe_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_instr,
  output logic                       out0_valid,
  output logic [31:0]                out0_instr,
  output logic [31:0]                out0_pc,
  output logic                       out1_valid,
  output logic [31:0]                out1_instr,
  output logic [31:0]                out1_pc,
  input  logic [1:0]                 dq_take,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  pc;
  logic         space;
  logic         push;
  fetch_entry_t wr_data;
  fetch_entry_t rd0;
  fetch_entry_t rd1;

  assign imem_addr = pc;
  assign push      = fetch_en & ~redirect_valid & space;
  assign wr_data   = '{instr: imem_instr, pc: pc};

  always_ff @(posedge clk) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & 32'hFFFF_FFFC;
    else if (push)           pc <= pc + 32'd4;
  end

  fetch_fifo_1w2r #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect_valid),
    .push    (push),
    .wr_data (wr_data),
    .take    (dq_take),
    .space   (space),
    .rd0     (rd0),
    .rd1     (rd1),
    .count   (q_count)
  );

  assign out0_valid = q_count >= CW'(1);
  assign out1_valid = q_count >= CW'(2);
  assign out0_instr = rd0.instr;
  assign out0_pc    = rd0.pc;
  assign out1_instr = rd1.instr;
  assign out1_pc    = rd1.pc;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; instruction memory returns word index (mem[i] = i).
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out0_valid;
  logic [31:0] out0_instr;
  logic [31:0] out0_pc;
  logic        out1_valid;
  logic [31:0] out1_instr;
  logic [31:0] out1_pc;
  logic [1:0]  dq_take;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  q_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = {2'b00, imem_addr[31:2]};

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out0_valid     (out0_valid),
    .out0_instr     (out0_instr),
    .out0_pc        (out0_pc),
    .out1_valid     (out1_valid),
    .out1_instr     (out1_instr),
    .out1_pc        (out1_pc),
    .dq_take        (dq_take),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .q_count        (q_count)
  );

  typedef struct {
    logic        rst;
    logic        fe;
    logic [1:0]  take;
    logic        rv;
    logic [31:0] rpc;
    logic [2:0]  ecount;
    logic [31:0] eaddr;
    logic        ev0;
    logic [31:0] epc0;
    logic        ev1;
    logic [31:0] epc1;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] ecount, input logic [31:0] eaddr,
                               input logic ev0, input logic [31:0] epc0,
                               input logic ev1, input logic [31:0] epc1);
    check({tag, ".q_count"},    32'(q_count), 32'(ecount));
    check({tag, ".imem_addr"},  imem_addr, eaddr);
    check({tag, ".out0_valid"}, 32'(out0_valid), 32'(ev0));
    check({tag, ".out1_valid"}, 32'(out1_valid), 32'(ev1));
    if (ev0) begin
      check({tag, ".out0_pc"},    out0_pc, epc0);
      check({tag, ".out0_instr"}, out0_instr, {2'b00, epc0[31:2]});
    end
    if (ev1) begin
      check({tag, ".out1_pc"},    out1_pc, epc1);
      check({tag, ".out1_instr"}, out1_instr, {2'b00, epc1[31:2]});
    end
  endtask

  task automatic drive(input logic rst, input logic fe, input logic [1:0] take,
                       input logic rv, input logic [31:0] rpc);
    reset          = rst;
    fetch_en       = fe;
    dq_take        = take;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst fe take rv rpc | count addr v0 pc0 v1 pc1
    vq.push_back('{0,1,0,0,32'h0,         1,32'h04,        1,32'h00,0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         2,32'h08,        1,32'h00,1,32'h04});
    vq.push_back('{0,1,0,0,32'h0,         3,32'h0C,        1,32'h00,1,32'h04});
    vq.push_back('{0,1,0,0,32'h0,         4,32'h10,        1,32'h00,1,32'h04});
    vq.push_back('{0,1,0,0,32'h0,         4,32'h10,        1,32'h00,1,32'h04});
    vq.push_back('{0,1,1,0,32'h0,         4,32'h14,        1,32'h04,1,32'h08});
    vq.push_back('{0,1,1,0,32'h0,         4,32'h18,        1,32'h08,1,32'h0C});
    vq.push_back('{0,1,3,0,32'h0,         3,32'h1C,        1,32'h10,1,32'h14});
    vq.push_back('{0,0,2,0,32'h0,         1,32'h1C,        1,32'h18,0,32'h0});
    vq.push_back('{0,0,2,0,32'h0,         0,32'h1C,        0,32'h0, 0,32'h0});
    vq.push_back('{0,0,0,0,32'h0,         0,32'h1C,        0,32'h0, 0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         1,32'h20,        1,32'h1C,0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         2,32'h24,        1,32'h1C,1,32'h20});
    vq.push_back('{0,1,0,0,32'h0,         3,32'h28,        1,32'h1C,1,32'h20});
    vq.push_back('{0,1,0,0,32'h0,         4,32'h2C,        1,32'h1C,1,32'h20});
    vq.push_back('{0,1,2,1,32'h40,        0,32'h40,        0,32'h0, 0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         1,32'h44,        1,32'h40,0,32'h0});
    vq.push_back('{0,1,0,1,32'h43,        0,32'h40,        0,32'h0, 0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         1,32'h44,        1,32'h40,0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         2,32'h48,        1,32'h40,1,32'h44});
    vq.push_back('{0,1,0,0,32'h0,         3,32'h4C,        1,32'h40,1,32'h44});
    vq.push_back('{1,1,1,1,32'h80,        0,32'h00,        0,32'h0, 0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         1,32'h04,        1,32'h00,0,32'h0});
    vq.push_back('{0,0,1,1,32'hFFFF_FFFC, 0,32'hFFFF_FFFC, 0,32'h0, 0,32'h0});
    vq.push_back('{0,1,0,0,32'h0,         1,32'h00,        1,32'hFFFF_FFFC,0,32'h0});

    drive(1, 0, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 32'h0);
    check_outputs("reset", 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].fe, vq[i].take, vq[i].rv, vq[i].rpc);
      check_outputs($sformatf("vec%0d", i), vq[i].ecount, vq[i].eaddr,
                    vq[i].ev0, vq[i].epc0, vq[i].ev1, vq[i].epc1);
    end

    // Steady state with a full queue: one push and one pop every cycle.
    drive(1, 0, 0, 0, 32'h0);
    for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 32'h0);
    check_outputs("fill", 3'd4, 32'h10, 1'b1, 32'h0, 1'b1, 32'h4);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 1, 1, 0, 32'h0);
      check_outputs($sformatf("stream%0d", k), 3'd4, 32'h10 + 32'(4 * k),
                    1'b1, 32'(4 * k), 1'b1, 32'(4 * k + 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
